// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-control types: controller FSM states and stage indices
package pipe_pkg;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RUN   = 2'd1,
      S_MWAIT = 2'd2
   } state_e;

   // Stage index shared with the hazard/forwarding unit.
   typedef enum logic [2:0] {
      STG_IF  = 3'd0,
      STG_ID  = 3'd1,
      STG_EX  = 3'd2,
      STG_MEM = 3'd3,
      STG_WB  = 3'd4
   } stage_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - CW-bit counter with clear/load/increment/decrement, saturating at both ends
module sat_counter #(
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + CW'(1);
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hold/clear generator for the pipeline stage registers and PC
// Resolves memory-wait, branch-flush and decode (load-use, mult/div) hazards by fixed priority.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LAT = 32,
   parameter int CW     = 6,
   parameter int TMO    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic id_load_use,
   input  logic id_md_start,
   input  logic id_md_read,
   input  logic mem_branch_taken,
   input  logic mem_dreq,
   input  logic mem_dack,
   output logic pc_hold,
   output logic ifid_hold,
   output logic ifid_clear,
   output logic idex_hold,
   output logic idex_clear,
   output logic exmem_hold,
   output logic exmem_clear,
   output logic memwb_hold,
   output logic memwb_clear,
   output logic md_start_ok,
   output logic md_busy,
   output logic mem_timeout
);

   state_e        state_q, state_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] md_cnt, wait_cnt;
   logic          in_init, in_mwait, stall_mem, ld_stall, wait_hit;

   assign in_init   = (state_q == S_INIT);
   assign in_mwait  = (state_q == S_MWAIT);
   assign stall_mem = mem_dreq & ~mem_dack & ~in_init;
   assign md_busy   = (md_cnt != '0);
   assign ld_stall  = id_load_use | ((id_md_start | id_md_read) & md_busy);
   // wait_cnt reaches TMO at the end of this cycle; raise the sticky flag alongside it.
   assign wait_hit  = in_mwait & (wait_cnt == CW'(TMO - 1));

   always_comb begin
      state_d     = in_init ? S_RUN : (stall_mem ? S_MWAIT : S_RUN);
      timeout_d   = timeout_q | wait_hit;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_clear  = 1'b0;
      idex_hold   = 1'b0;
      idex_clear  = 1'b0;
      exmem_hold  = 1'b0;
      exmem_clear = 1'b0;
      memwb_hold  = 1'b0;
      memwb_clear = 1'b0;
      md_start_ok = 1'b0;
      if (in_init) begin
         pc_hold     = 1'b1;
         ifid_clear  = 1'b1;
         idex_clear  = 1'b1;
         exmem_clear = 1'b1;
         memwb_clear = 1'b1;
      end else begin
         md_start_ok = id_md_start & ~md_busy & ~stall_mem & ~mem_branch_taken & ~id_load_use;
         if (stall_mem) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_clear = 1'b1;
         end else if (mem_branch_taken) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
         end else if (ld_stall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_clear  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_INIT;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;

   // The mult/div unit runs free: it keeps counting through stalls and flushes.
   sat_counter #(.CW(CW)) u_md_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (1'b0),
      .load_i     (md_start_ok),
      .load_val_i (CW'(MD_LAT)),
      .inc_i      (1'b0),
      .dec_i      (1'b1),
      .cnt_o      (md_cnt)
   );

   sat_counter #(.CW(CW)) u_wait_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (~in_mwait),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (in_mwait),
      .dec_i      (1'b0),
      .cnt_o      (wait_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl: directed table, corner sequences, random vs model
module tb_pipe_ctrl;

   localparam int MD_LAT = 4;
   localparam int CW     = 6;
   localparam int TMO    = 16;

   // Output order: pc_hold, ifid_h, ifid_c, idex_h, idex_c, exmem_h, exmem_c, memwb_h, memwb_c, md_ok, md_busy, timeout
   localparam logic [11:0] O_RST  = 12'b101010101000;
   localparam logic [11:0] O_LU   = 12'b110010000000;
   localparam logic [11:0] O_MEM  = 12'b110101001000;
   localparam logic [11:0] O_BR   = 12'b001010100000;
   localparam logic [11:0] O_MDOK = 12'b000000000100;
   localparam logic [11:0] O_MDHZ = 12'b110010000010;

   // Input order: id_load_use, id_md_start, id_md_read, mem_branch_taken, mem_dreq, mem_dack
   typedef struct {
      logic [5:0]  in;
      logic [11:0] exp;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_load_use = 1'b0, id_md_start = 1'b0, id_md_read = 1'b0;
   logic mem_branch_taken = 1'b0, mem_dreq = 1'b0, mem_dack = 1'b0;
   logic pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
   logic exmem_hold, exmem_clear, memwb_hold, memwb_clear;
   logic md_start_ok, md_busy, mem_timeout;

   int n_vec = 0;
   int n_bad = 0;

   bit m_init, m_waiting, m_tmo;
   int m_md_rem, m_waits;

   vec_t tbl[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.MD_LAT(MD_LAT), .CW(CW), .TMO(TMO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_load_use      (id_load_use),
      .id_md_start      (id_md_start),
      .id_md_read       (id_md_read),
      .mem_branch_taken (mem_branch_taken),
      .mem_dreq         (mem_dreq),
      .mem_dack         (mem_dack),
      .pc_hold          (pc_hold),
      .ifid_hold        (ifid_hold),
      .ifid_clear       (ifid_clear),
      .idex_hold        (idex_hold),
      .idex_clear       (idex_clear),
      .exmem_hold       (exmem_hold),
      .exmem_clear      (exmem_clear),
      .memwb_hold       (memwb_hold),
      .memwb_clear      (memwb_clear),
      .md_start_ok      (md_start_ok),
      .md_busy          (md_busy),
      .mem_timeout      (mem_timeout)
   );

   function automatic logic [11:0] actual();
      return {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_hold,
              exmem_clear, memwb_hold, memwb_clear, md_start_ok, md_busy, mem_timeout};
   endfunction

   function automatic logic [11:0] model_out(logic [5:0] in);
      logic [11:0] o;
      bit lu, ms, mr, bt, stall, busy;
      lu = in[5]; ms = in[4]; mr = in[3]; bt = in[2];
      stall = in[1] & ~in[0];
      busy  = (m_md_rem > 0);
      o = '0;
      if (m_init) return O_RST;
      if (stall) begin
         o[11] = 1; o[10] = 1; o[8] = 1; o[6] = 1; o[3] = 1;
      end else if (bt) begin
         o[9] = 1; o[7] = 1; o[5] = 1;
      end else if (lu || ((ms || mr) && busy)) begin
         o[11] = 1; o[10] = 1; o[7] = 1;
      end
      o[2] = ms & ~busy & ~stall & ~bt & ~lu;
      o[1] = busy;
      o[0] = m_tmo;
      return o;
   endfunction

   task automatic model_step(input logic [5:0] in, input logic [11:0] o);
      bit was_waiting;
      was_waiting = m_waiting;
      if (m_init) begin
         m_init = 0;
         m_waiting = 0;
      end else begin
         m_waiting = in[1] & ~in[0];
      end
      if (o[2]) m_md_rem = MD_LAT;
      else if (m_md_rem > 0) m_md_rem--;
      if (was_waiting) m_waits = (m_waits < (1 << CW) - 1) ? m_waits + 1 : m_waits;
      else m_waits = 0;
      if (m_waits == TMO) m_tmo = 1;
   endtask

   task automatic check(input logic [11:0] exp, input string name);
      n_vec++;
      if (actual() !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, actual(), exp);
      end
   endtask

   // Entered at posedge+1; drives one cycle, checks mid-cycle, returns at next posedge+1.
   task automatic apply(input logic [5:0] in, input logic [11:0] exp, input string name);
      logic [11:0] mo;
      {id_load_use, id_md_start, id_md_read, mem_branch_taken, mem_dreq, mem_dack} = in;
      #2;
      mo = model_out(in);
      check(exp, name);
      @(posedge clk);
      model_step(in, mo);
      #1;
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      {id_load_use, id_md_start, id_md_read, mem_branch_taken, mem_dreq, mem_dack} = '0;
      m_init = 1; m_waiting = 0; m_md_rem = 0; m_waits = 0; m_tmo = 0;
      #1;
      check(O_RST, {name, "_async"});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check(O_RST, {name, "_held"});
      end
      rst_n = 1'b1;
   endtask

   task automatic add(input logic [5:0] in, input logic [11:0] exp, input string name);
      vec_t v;
      v.in = in; v.exp = exp; v.name = name;
      tbl.push_back(v);
   endtask

   initial begin
      add(6'b100010, O_RST, "init_cycle");
      add(6'b000000, '0,    "run_idle");
      add(6'b100000, O_LU,  "load_use");
      add(6'b000000, '0,    "after_lu");
      for (int i = 0; i < 5; i++) add(6'b000010, O_MEM, "mem_wait");
      add(6'b000011, '0,    "mem_dack");
      add(6'b000000, '0,    "after_dack");
      add(6'b010000, O_MDOK, "md_start");
      for (int i = 0; i < 4; i++) add(6'b001000, O_MDHZ, "md_read_busy");
      add(6'b001000, '0,    "md_read_free");
      add(6'b100100, O_BR,  "branch_vs_lu");
      add(6'b100110, O_MEM, "mem_vs_branch");
      add(6'b000000, '0,    "after_mixed");

      @(posedge clk);
      #1;
      do_reset("reset");
      foreach (tbl[i]) apply(tbl[i].in, tbl[i].exp, tbl[i].name);

      for (int k = 1; k <= 20; k++)
         apply(6'b000010, (k >= 18) ? (O_MEM | 12'b1) : O_MEM, "tmo_wait");
      apply(6'b000011, 12'b1, "tmo_dack");
      apply(6'b000000, 12'b1, "tmo_sticky");
      apply(6'b010000, O_MDOK | 12'b1, "md_start_pre_rst");
      do_reset("rst_mid_md");
      apply(6'b000000, O_RST, "init_after_rst");

      for (int i = 0; i < 600; i++) begin
         logic [5:0] in;
         in[5] = ($urandom_range(0, 3) == 0);
         in[4] = ($urandom_range(0, 3) == 0);
         in[3] = ($urandom_range(0, 3) == 0);
         in[2] = ($urandom_range(0, 7) == 0);
         in[1] = ($urandom_range(0, 2) == 0);
         in[0] = ($urandom_range(0, 1) == 0);
         apply(in, model_out(in), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
